pool2: RTL and testbench

POOL2 -- requirements
Module: pool2

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/max4_unit.sv | 41 ++++
 rtl/pool2.sv | 200 ++++++++++++++++++++
 tb/tb_pool2.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN constants and the pool2 controller state type.
// Layer sizes here are the defaults for the pool2 block and its neighbours.
package cnn_pkg;

    localparam int CONV2_CH  = 32;
    localparam int CONV2_DIM = 14;
    localparam int POOL2_DIM = 7;

    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        WAIT_START_LOW
    } pool2_state_t;

    // Signed maximum of two pixels; on a tie either operand is acceptable.
    function automatic pixel_t max2(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max4_unit.sv
// Two-stage signed maximum of four values.
// Stage 1 reduces two pairs, stage 2 reduces the pair results; valid
// travels with the data so the unit has a fixed latency of two cycles.
module max4_unit
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] in0,
    input  logic signed [DATA_W-1:0] in1,
    input  logic signed [DATA_W-1:0] in2,
    input  logic signed [DATA_W-1:0] in3,
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] max_out
);

    logic   s1_valid;
    pixel_t s1_max_a;
    pixel_t s1_max_b;

    // Valid bits for both stages; cleared by reset so no stale window is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            s1_valid  <= valid_in;
            valid_out <= s1_valid;
        end
    end

    // Datapath registers: pairwise maxima, then the final maximum.
    // NOTE: data registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        s1_max_a <= max2(in0, in1);
        s1_max_b <= max2(in2, in3);
        max_out  <= max2(s1_max_a, s1_max_b);
    end

endmodule

// File: rtl/pool2.sv
// 2x2 / stride-2 signed max pooling over CH feature maps of IN_DIM x IN_DIM.
// One window issues per cycle in RUN; results land in pool2_maps two cycles
// later through max4_unit. Build option: define POOL2_PERF_CNT_EN to add the
// cycle_count output (cycles spent in RUN and DRAIN for the last run).
module pool2
    import cnn_pkg::*;
#(
    parameter  int CH      = CONV2_CH,
    parameter  int IN_DIM  = CONV2_DIM,
    localparam int OUT_DIM = IN_DIM / 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     done,
    output logic                     busy,
    input  logic signed [DATA_W-1:0] conv2_maps [0:CH-1][0:IN_DIM-1][0:IN_DIM-1],
    output logic signed [DATA_W-1:0] pool2_maps [0:CH-1][0:OUT_DIM-1][0:OUT_DIM-1]
`ifdef POOL2_PERF_CNT_EN
    ,
    output logic [15:0]              cycle_count
`endif
);

    localparam int FW = (CH > 1) ? $clog2(CH) : 1;
    localparam int IW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [FW-1:0] F_LAST = FW'(CH - 1);
    localparam logic [IW-1:0] I_LAST = IW'(OUT_DIM - 1);

    pool2_state_t state;

    // Window issue position: j fastest, then i, then f.
    logic [FW-1:0] f;
    logic [IW-1:0] i;
    logic [IW-1:0] j;

    logic          issue_valid;
    logic          last_window;
    logic [IW:0]   row0;
    logic [IW:0]   row1;
    logic [IW:0]   col0;
    logic [IW:0]   col1;
    pixel_t        win0;
    pixel_t        win1;
    pixel_t        win2;
    pixel_t        win3;

    // Tags travelling alongside the max4 pipeline.
    logic          s1_valid;
    logic [FW-1:0] s1_f;
    logic [IW-1:0] s1_i;
    logic [IW-1:0] s1_j;
    logic [FW-1:0] s2_f;
    logic [IW-1:0] s2_i;
    logic [IW-1:0] s2_j;

    logic          mx_valid;
    pixel_t        mx_out;

    assign issue_valid = (state == RUN);
    assign last_window = (f == F_LAST) && (i == I_LAST) && (j == I_LAST);

    assign row0 = {i, 1'b0};
    assign row1 = {i, 1'b1};
    assign col0 = {j, 1'b0};
    assign col1 = {j, 1'b1};

    // Fetch the 2x2 window for the current issue position.
    // NOTE: every always_comb output is assigned on every path, so no latch can form.
    always_comb begin
        win0 = conv2_maps[f][row0][col0];
        win1 = conv2_maps[f][row0][col1];
        win2 = conv2_maps[f][row1][col0];
        win3 = conv2_maps[f][row1][col1];
    end

    // Controller: sequencing, issue counters and registered status outputs.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
            f     <= '0;
            i     <= '0;
            j     <= '0;
`ifdef POOL2_PERF_CNT_EN
            cycle_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        f     <= '0;
                        i     <= '0;
                        j     <= '0;
`ifdef POOL2_PERF_CNT_EN
                        cycle_count <= '0;
`endif
                    end
                end
                RUN: begin
`ifdef POOL2_PERF_CNT_EN
                    cycle_count <= cycle_count + 16'd1;
`endif
                    if (last_window) begin
                        state <= DRAIN;
                    end else if (j == I_LAST) begin
                        j <= '0;
                        if (i == I_LAST) begin
                            i <= '0;
                            f <= f + 1'b1;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DRAIN: begin
`ifdef POOL2_PERF_CNT_EN
                    cycle_count <= cycle_count + 16'd1;
`endif
                    // Stage 1 empty means the final window writes on this edge.
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= WAIT_START_LOW;
                    done  <= 1'b1;
                end
                WAIT_START_LOW: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Carry window coordinates in step with the comparator stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
            s1_i     <= '0;
            s1_j     <= '0;
            s2_f     <= '0;
            s2_i     <= '0;
            s2_j     <= '0;
        end else begin
            s1_valid <= issue_valid;
            s1_f     <= f;
            s1_i     <= i;
            s1_j     <= j;
            s2_f     <= s1_f;
            s2_i     <= s1_i;
            s2_j     <= s1_j;
        end
    end

    max4_unit u_max4 (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (issue_valid),
        .in0       (win0),
        .in1       (win1),
        .in2       (win2),
        .in3       (win3),
        .valid_out (mx_valid),
        .max_out   (mx_out)
    );

    // Result store: one entry written per valid stage-2 result; reset clears all.
    // NOTE: this array is reset entry by entry because its cleared contents are visible at the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                for (int r = 0; r < OUT_DIM; r++) begin
                    for (int k = 0; k < OUT_DIM; k++) begin
                        pool2_maps[c][r][k] <= '0;
                    end
                end
            end
        end else if (mx_valid) begin
            pool2_maps[s2_f][s2_i][s2_j] <= mx_out;
        end
    end

endmodule

// File: tb/tb_pool2.sv
// Self-checking bench for pool2: directed input maps, a behavioural pooling
// and timing model, a per-cycle compare process, and literal spot checks.
module tb_pool2;
    import cnn_pkg::*;

    localparam int CH       = CONV2_CH;
    localparam int IN_DIM   = CONV2_DIM;
    localparam int OUT_DIM  = POOL2_DIM;
    localparam int WINDOWS  = CH * OUT_DIM * OUT_DIM;
    // Busy covers every issue cycle plus two pipeline cycles; done follows DONE.
    localparam int BUSY_LAST = WINDOWS + 2;
    localparam int DONE_AT   = WINDOWS + 4;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done;
    logic busy;
    logic signed [31:0] conv2_maps [0:CH-1][0:IN_DIM-1][0:IN_DIM-1];
    logic signed [31:0] pool2_maps [0:CH-1][0:OUT_DIM-1][0:OUT_DIM-1];
`ifdef POOL2_PERF_CNT_EN
    logic [15:0] cycle_count;
`endif

    // Model state
    logic signed [31:0] run_maps [0:CH-1][0:OUT_DIM-1][0:OUT_DIM-1];
    bit m_active = 1'b0;
    int t0 = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    int rise_count = 0;

    int n_vec = 0;
    int n_err = 0;

    pool2 #(.CH(CH), .IN_DIM(IN_DIM)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .conv2_maps (conv2_maps),
        .pool2_maps (pool2_maps)
`ifdef POOL2_PERF_CNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge done);
            rise_count++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference pooling: plain signed max over each 2x2 block.
    task automatic model_pool();
        logic signed [31:0] m;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OUT_DIM; r++)
                for (int k = 0; k < OUT_DIM; k++) begin
                    m = conv2_maps[c][2*r][2*k];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (conv2_maps[c][2*r+dr][2*k+dc] > m)
                                m = conv2_maps[c][2*r+dr][2*k+dc];
                    run_maps[c][r][k] = m;
                end
    endtask

    // mode 0: ramp, 1: descending from 1000, 2: constant value v
    task automatic fill(input int mode, input int v);
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IN_DIM; r++)
                for (int k = 0; k < IN_DIM; k++)
                    case (mode)
                        0: conv2_maps[c][r][k] = 32'(c*196 + r*14 + k);
                        1: conv2_maps[c][r][k] = 32'(1000 - (c*196 + r*14 + k));
                        default: conv2_maps[c][r][k] = 32'(v);
                    endcase
    endtask

    // Per-cycle comparison of status, maps and optional counter against the model.
    task automatic compare_cycle();
        int k;
        bit exp_busy;
        bit exp_done;
        bit bad;
        logic signed [31:0] a;
        logic signed [31:0] e;
        k = cyc - t0;
        exp_busy = m_active && (k >= 1) && (k <= BUSY_LAST);
        exp_done = m_active && (k >= DONE_AT);
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        if (!m_active || k >= DONE_AT - 1) begin
            bad = 1'b0;
            a = pool2_maps[0][0][0];
            e = m_active ? run_maps[0][0][0] : 32'sd0;
            for (int c = 0; c < CH; c++)
                for (int r = 0; r < OUT_DIM; r++)
                    for (int q = 0; q < OUT_DIM; q++)
                        if (!bad && pool2_maps[c][r][q] !== (m_active ? run_maps[c][r][q] : 32'sd0)) begin
                            bad = 1'b1;
                            a = pool2_maps[c][r][q];
                            e = m_active ? run_maps[c][r][q] : 32'sd0;
                        end
            check("pool2_maps", a, e);
        end
`ifdef POOL2_PERF_CNT_EN
        if (m_active)
            check("cycle_count", cycle_count, (k - 1 < BUSY_LAST) ? k - 1 : BUSY_LAST);
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmp_en) compare_cycle();
        end
    end

    // Called at a negedge: request a run and record the acceptance cycle.
    task automatic start_run();
        model_pool();
        t0 = cyc;
        m_active = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int first_done;
        reset = 1'b1;
        start = 1'b0;
        fill(0, 0);
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Ramp: result is the bottom-right element of each window.
        fill(0, 0);
        start_run();
        first_done = -1;
        for (int n = 0; n < 2000 && first_done < 0; n++) begin
            @(negedge clk);
            if (done) first_done = cyc;
        end
        check("done_first_cycle", first_done - t0, 1572);
        repeat (3) @(negedge clk);
        check("model_ramp_1_2_3", run_maps[1][2][3], 32'sd273);
        check("ramp_0_0_0", pool2_maps[0][0][0], 32'sd15);
        check("ramp_31_6_6", pool2_maps[31][6][6], 32'sd6271);
`ifdef POOL2_PERF_CNT_EN
        check("cycle_count_full", cycle_count, 16'd1570);
`endif

        // Reset mid-run, then a clean ramp run.
        start_run();
        while (cyc < t0 + 500) @(negedge clk);
        reset = 1'b1;
        m_active = 1'b0;
        #1;
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_map_0_0_0", pool2_maps[0][0][0], 32'sd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        start_run();
        repeat (DONE_AT + 3) @(negedge clk);
        check("ramp2_5_3_4", pool2_maps[5][3][4], 32'sd1087);

        // Negative values pass through unchanged.
        fill(2, -5);
        conv2_maps[3][4][5] = -32'sd2;
        start_run();
        repeat (DONE_AT + 3) @(negedge clk);
        check("neg_3_2_2", pool2_maps[3][2][2], -32'sd2);
        check("neg_3_2_3", pool2_maps[3][2][3], -32'sd5);
        check("neg_0_0_0", pool2_maps[0][0][0], -32'sd5);

        // Ties and signed extremes.
        fill(2, 0);
        conv2_maps[0][0][0] = 32'sd7;
        conv2_maps[0][0][1] = 32'sd7;
        conv2_maps[0][1][0] = 32'sd7;
        conv2_maps[0][1][1] = 32'sd7;
        conv2_maps[0][0][2] = 32'sh7FFFFFFF;
        conv2_maps[0][0][3] = 32'sh80000000;
        start_run();
        repeat (DONE_AT + 3) @(negedge clk);
        check("tie_all_7", pool2_maps[0][0][0], 32'sd7);
        check("tie_extremes", pool2_maps[0][0][1], 32'sh7FFFFFFF);

        // Start held high: one run only, then a second run after release.
        fill(1, 0);
        rise_count = 0;
        model_pool();
        t0 = cyc;
        m_active = 1'b1;
        start = 1'b1;
        repeat (3000) @(negedge clk);
        check("held_done_rises", rise_count, 1);
        check("held_busy", busy, 1'b0);
        check("held_max_0_0_0", pool2_maps[0][0][0], 32'sd1000);
        start = 1'b0;
        repeat (3) @(negedge clk);
        fill(0, 0);
        start_run();
        repeat (100) @(negedge clk);
        check("rerun_done_low", done, 1'b0);
        repeat (DONE_AT) @(negedge clk);
        check("rerun_done_rises", rise_count, 2);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
